// File: rtl/dense_neuron_mac_if.sv
// Bus bundle for dense_neuron_mac.
// Signals (directions as seen by the neuron, slave modport):
//   x_tdata/x_tvalid  in   pixel sample stream; x_tready out
//   w_wr_en/w_wr_addr/w_wr_data  in  weight memory write port
//   bias              in   neuron bias, static during a frame
//   y_tdata/y_tvalid  out  neuron result stream; y_tready in
//   busy              out  high whenever the neuron is not idle
interface dense_neuron_mac_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic [DATA_W-1:0] x_tdata;
    logic              x_tvalid;
    logic              x_tready;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] bias;
    logic [DATA_W-1:0] y_tdata;
    logic              y_tvalid;
    logic              y_tready;
    logic              busy;

    modport master (
        output x_tdata, x_tvalid, w_wr_en, w_wr_addr, w_wr_data, bias, y_tready,
        input  x_tready, y_tdata, y_tvalid, busy
    );

    modport slave (
        input  x_tdata, x_tvalid, w_wr_en, w_wr_addr, w_wr_data, bias, y_tready,
        output x_tready, y_tdata, y_tvalid, busy
    );
endinterface

// File: rtl/dense_neuron_mac.sv
// Single dense-layer neuron: y = sat((sum_k x[k]*w[k] + bias) >>> FRAC_BITS), all data signed
// fixed point with FRAC_BITS fraction bits.
// Ports:
//   s_axi_aclk     clock
//   s_axi_aresetn  asynchronous active-low reset
//   bus            dense_neuron_mac_if.slave: x stream in, weight write port, bias,
//                  y stream out, busy
// Optional build macro NEURON_RELU_EN: clamp negative results to zero.
module dense_neuron_mac #(
    parameter int unsigned N_INPUTS  = 784,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    dense_neuron_mac_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SatMax =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StFinish, StOutput} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      prod_vld_q, prod_vld_d;
    logic [DATA_W-1:0]         y_data_q, y_data_d;
    logic                      y_vld_q, y_vld_d;
    logic                      out_en_q;  // holds x_tready low until the first edge after reset
    logic [DATA_W-1:0]         w_mem [N_INPUTS];
    logic [DATA_W-1:0]         w_rd_q;
    logic                      x_hs;
    logic                      w_we;
    logic signed [PROD_W-1:0]  x_ext, w_ext;
    logic signed [ACC_W-1:0]   bias_ext, sum, shifted, sat;
    logic [DATA_W-1:0]         result;

    assign bus.x_tready = out_en_q && (state_q == StIdle || state_q == StAccum);
    assign bus.y_tdata  = y_data_q;
    assign bus.y_tvalid = y_vld_q;
    assign bus.busy     = (state_q != StIdle);

    assign x_hs = bus.x_tvalid && bus.x_tready;
    assign w_we = bus.w_wr_en && (state_q == StIdle) &&
                  ({1'b0, bus.w_wr_addr} < (ADDR_W + 1)'(N_INPUTS));

    assign x_ext = {{DATA_W{bus.x_tdata[DATA_W-1]}}, bus.x_tdata};
    assign w_ext = {{DATA_W{w_rd_q[DATA_W-1]}}, w_rd_q};

    // Result datapath: add bias aligned to the product's 2*FRAC_BITS scale, rescale, saturate.
    always_comb begin
        bias_ext = {{(ACC_W - DATA_W){bus.bias[DATA_W-1]}}, bus.bias} <<< FRAC_BITS;
        sum      = acc_q + bias_ext;
        shifted  = sum >>> FRAC_BITS;
        if (shifted > SatMax) begin
            sat = SatMax;
        end else if (shifted < SatMin) begin
            sat = SatMin;
        end else begin
            sat = shifted;
        end
`ifdef NEURON_RELU_EN
        result = sat[ACC_W-1] ? '0 : sat[DATA_W-1:0];
`else
        result = sat[DATA_W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        y_data_d   = y_data_q;
        y_vld_d    = y_vld_q;

        // Product stage feeds the accumulator one cycle later.
        if (prod_vld_q) begin
            acc_d = acc_q + {{ADDR_W{prod_q[PROD_W-1]}}, prod_q};
        end
        if (x_hs) begin
            prod_d     = x_ext * w_ext;
            prod_vld_d = 1'b1;
        end

        case (state_q)
            StIdle, StAccum: begin
                if (x_hs) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = StAccum;
                    end
                end
            end
            StFinish: begin
                // Wait until the last product has landed in the accumulator.
                if (!prod_vld_q) begin
                    y_data_d = result;
                    y_vld_d  = 1'b1;
                    state_d  = StOutput;
                end
            end
            StOutput: begin
                if (bus.y_tready) begin
                    y_vld_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            y_data_q   <= '0;
            y_vld_q    <= 1'b0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            y_data_q   <= y_data_d;
            y_vld_q    <= y_vld_d;
            out_en_q   <= 1'b1;
        end
    end

    // Weight storage is deliberately not reset so weights survive a reset.
    always_ff @(posedge s_axi_aclk) begin
        if (w_we) begin
            w_mem[bus.w_wr_addr] <= bus.w_wr_data;
        end
    end

    // Prefetch the weight for the next sample index; bypass a same-cycle write to it.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_rd_q <= '0;
        end else if (w_we && (bus.w_wr_addr == cnt_d)) begin
            w_rd_q <= bus.w_wr_data;
        end else begin
            w_rd_q <= w_mem[cnt_d];
        end
    end
endmodule
